// File: rtl/ts_rx_parser.sv
// Receive-side training ordered-set parser: validates TS1/TS2 symbol streams,
// publishes the fields of each good set and counts consecutive identical sets.
module ts_rx_parser #(
   parameter int CONS_TARGET = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] sym_in,
   input  logic       sym_k,
   input  logic       sym_vld,
   input  logic       clear_cnt,
   output logic       ts_vld,
   output logic       ts_type,
   output logic [7:0] link_num,
   output logic [7:0] lane_num,
   output logic [7:0] n_fts,
   output logic [7:0] rate_id,
   output logic [7:0] train_ctl,
   output logic       link_pad,
   output logic       lane_pad,
   output logic [3:0] ts_cons_cnt,
   output logic       ts_cons_hit,
   output logic       ts_err
);
   localparam logic [7:0] SYM_COM = 8'hBC;
   localparam logic [7:0] SYM_PAD = 8'hF7;
   localparam logic [7:0] ID_TS1  = 8'h4A;
   localparam logic [7:0] ID_TS2  = 8'h45;
   localparam logic [3:0] TARGET  = 4'(CONS_TARGET);
   localparam int         SET_W   = 50;

   typedef enum logic {HUNT, COLLECT} state_t;

   state_t           state;
   logic [3:0]       idx;
   logic [7:0]       buf_link, buf_lane, buf_nfts, buf_rate, buf_ctl, buf_id;
   logic             buf_link_k, buf_lane_k;
   logic [SET_W-1:0] hist_set;
   logic             hist_valid;

   logic             sym_ok, is_com, collect_step, set_done, violation, same_as_hist;
   logic [SET_W-1:0] new_set;
   logic [3:0]       cnt_next;

   assign is_com       = sym_k && (sym_in == SYM_COM);
   assign collect_step = (state == COLLECT) && sym_vld;
   assign set_done     = collect_step && sym_ok && (idx == 4'd15);
   assign violation    = collect_step && !sym_ok;

   // Symbols 6..15 all equal the identifier, so sym1..6 plus the two K flags
   // fully describe a good set for the history comparison.
   assign new_set      = {buf_link_k, buf_link, buf_lane_k, buf_lane,
                          buf_nfts, buf_rate, buf_ctl, buf_id};
   assign same_as_hist = hist_valid && (new_set == hist_set);

   always_comb begin
      sym_ok = 1'b0;
      case (idx)
         4'd1, 4'd2:       sym_ok = !sym_k || (sym_in == SYM_PAD);
         4'd3, 4'd4, 4'd5: sym_ok = !sym_k;
         4'd6:             sym_ok = !sym_k && ((sym_in == ID_TS1) || (sym_in == ID_TS2));
         default:          sym_ok = !sym_k && (sym_in == buf_id);
      endcase
   end

   // A completing good set takes priority over a coincident clear.
   always_comb begin
      cnt_next = ts_cons_cnt;
      if (set_done) begin
         if (same_as_hist && !clear_cnt)
            cnt_next = (ts_cons_cnt == 4'd15) ? 4'd15 : ts_cons_cnt + 4'd1;
         else
            cnt_next = 4'd1;
      end else if (violation || clear_cnt) begin
         cnt_next = 4'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= HUNT;
         idx         <= 4'd0;
         buf_link    <= '0;
         buf_lane    <= '0;
         buf_nfts    <= '0;
         buf_rate    <= '0;
         buf_ctl     <= '0;
         buf_id      <= '0;
         buf_link_k  <= 1'b0;
         buf_lane_k  <= 1'b0;
         hist_set    <= '0;
         hist_valid  <= 1'b0;
         ts_vld      <= 1'b0;
         ts_err      <= 1'b0;
         ts_type     <= 1'b0;
         link_num    <= '0;
         lane_num    <= '0;
         n_fts       <= '0;
         rate_id     <= '0;
         train_ctl   <= '0;
         link_pad    <= 1'b0;
         lane_pad    <= 1'b0;
         ts_cons_cnt <= '0;
         ts_cons_hit <= 1'b0;
      end else begin
         ts_vld      <= 1'b0;
         ts_err      <= 1'b0;
         ts_cons_cnt <= cnt_next;
         ts_cons_hit <= (cnt_next >= TARGET);
         if (set_done || violation || clear_cnt)
            hist_valid <= set_done;
         if (set_done)
            hist_set <= new_set;
         if (sym_vld) begin
            if (state == HUNT) begin
               if (is_com) begin
                  state <= COLLECT;
                  idx   <= 4'd1;
               end
            end else if (!sym_ok) begin
               ts_err <= 1'b1;
               if (is_com) begin
                  idx <= 4'd1;
               end else begin
                  state <= HUNT;
                  idx   <= 4'd0;
               end
            end else if (idx == 4'd15) begin
               state     <= HUNT;
               idx       <= 4'd0;
               ts_vld    <= 1'b1;
               ts_type   <= (buf_id == ID_TS2);
               link_num  <= buf_link;
               lane_num  <= buf_lane;
               n_fts     <= buf_nfts;
               rate_id   <= buf_rate;
               train_ctl <= buf_ctl;
               link_pad  <= buf_link_k;
               lane_pad  <= buf_lane_k;
            end else begin
               case (idx)
                  4'd1: begin
                     buf_link   <= sym_in;
                     buf_link_k <= sym_k;
                  end
                  4'd2: begin
                     buf_lane   <= sym_in;
                     buf_lane_k <= sym_k;
                  end
                  4'd3:    buf_nfts <= sym_in;
                  4'd4:    buf_rate <= sym_in;
                  4'd5:    buf_ctl  <= sym_in;
                  4'd6:    buf_id   <= sym_in;
                  default: ;
               endcase
               idx <= idx + 4'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_ts_rx_parser.sv
// Self-checking bench for ts_rx_parser: directed ordered-set scenarios plus
// randomized sets, compared every cycle against a set-level reference model.
`timescale 1ns/1ps
module tb_ts_rx_parser;
   localparam int         CONS_TARGET = 8;
   localparam logic [7:0] COM = 8'hBC;
   localparam logic [7:0] PAD = 8'hF7;
   localparam logic [7:0] TS1 = 8'h4A;
   localparam logic [7:0] TS2 = 8'h45;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sym_in;
   logic       sym_k, sym_vld, clear_cnt;
   logic       ts_vld, ts_type, link_pad, lane_pad, ts_cons_hit, ts_err;
   logic [7:0] link_num, lane_num, n_fts, rate_id, train_ctl;
   logic [3:0] ts_cons_cnt;

   int compared   = 0;
   int mismatched = 0;
   int vld_seen   = 0;

   logic [7:0]  cur_sym  [16];
   logic        cur_k    [16];
   logic [7:0]  hist_sym [16];
   logic        hist_k   [16];
   bit          hist_ok;
   int          m_cnt;
   logic [42:0] m_fields;
   logic        m_vld, m_err;

   ts_rx_parser #(.CONS_TARGET(CONS_TARGET)) dut (
      .clk(clk), .rst(rst), .sym_in(sym_in), .sym_k(sym_k), .sym_vld(sym_vld),
      .clear_cnt(clear_cnt), .ts_vld(ts_vld), .ts_type(ts_type),
      .link_num(link_num), .lane_num(lane_num), .n_fts(n_fts), .rate_id(rate_id),
      .train_ctl(train_ctl), .link_pad(link_pad), .lane_pad(lane_pad),
      .ts_cons_cnt(ts_cons_cnt), .ts_cons_hit(ts_cons_hit), .ts_err(ts_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed=running required=done");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] all_outputs();
      return 64'({ts_vld, ts_type, link_num, lane_num, n_fts, rate_id, train_ctl,
                  link_pad, lane_pad, ts_cons_cnt, ts_cons_hit, ts_err});
   endfunction

   task automatic checkAll(input string tag);
      if (ts_vld === 1'b1) vld_seen++;
      checkOutput({tag, ".vld"}, 64'(ts_vld), 64'(m_vld));
      checkOutput({tag, ".err"}, 64'(ts_err), 64'(m_err));
      checkOutput({tag, ".cnt"}, 64'(ts_cons_cnt), 64'(m_cnt));
      checkOutput({tag, ".hit"}, 64'(ts_cons_hit), 64'(m_cnt >= CONS_TARGET));
      checkOutput({tag, ".fields"},
                  64'({ts_type, link_pad, lane_pad, link_num, lane_num, n_fts, rate_id, train_ctl}),
                  64'(m_fields));
   endtask

   task automatic applyStimulus(input logic [7:0] s, input logic k, input logic v, input logic c);
      sym_in    = s;
      sym_k     = k;
      sym_vld   = v;
      clear_cnt = c;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      hist_ok  = 1'b0;
      m_cnt    = 0;
      m_fields = '0;
      m_vld    = 1'b0;
      m_err    = 1'b0;
   endtask

   // Index of the first symbol breaking the ordered-set rules, 16 when good.
   function automatic int first_bad();
      for (int i = 1; i < 16; i++) begin
         bit ok;
         if (i <= 2)      ok = !cur_k[i] || (cur_sym[i] == PAD);
         else if (i <= 5) ok = !cur_k[i];
         else if (i == 6) ok = !cur_k[i] && (cur_sym[i] == TS1 || cur_sym[i] == TS2);
         else             ok = !cur_k[i] && (cur_sym[i] == cur_sym[6]);
         if (!ok) return i;
      end
      return 16;
   endfunction

   function automatic bit matches_history();
      if (!hist_ok) return 1'b0;
      for (int i = 1; i < 16; i++)
         if (cur_sym[i] !== hist_sym[i] || cur_k[i] !== hist_k[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_good_set(input bit clr);
      if (!clr && matches_history()) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      else                           m_cnt = 1;
      for (int i = 0; i < 16; i++) begin
         hist_sym[i] = cur_sym[i];
         hist_k[i]   = cur_k[i];
      end
      hist_ok  = 1'b1;
      m_vld    = 1'b1;
      m_fields = {cur_sym[6] == TS2, cur_k[1], cur_k[2],
                  cur_sym[1], cur_sym[2], cur_sym[3], cur_sym[4], cur_sym[5]};
   endtask

   task automatic build_set(input bit lpad, input logic [7:0] link, input bit npad,
                            input logic [7:0] lane, input logic [7:0] nfts,
                            input logic [7:0] rate, input logic [7:0] ctl, input logic [7:0] id);
      cur_sym[0] = COM;  cur_k[0] = 1'b1;
      cur_sym[1] = lpad ? PAD : link;  cur_k[1] = lpad;
      cur_sym[2] = npad ? PAD : lane;  cur_k[2] = npad;
      cur_sym[3] = nfts; cur_k[3] = 1'b0;
      cur_sym[4] = rate; cur_k[4] = 1'b0;
      cur_sym[5] = ctl;  cur_k[5] = 1'b0;
      for (int i = 6; i < 16; i++) begin
         cur_sym[i] = id;
         cur_k[i]   = 1'b0;
      end
   endtask

   task automatic build_random_set();
      build_set($urandom_range(99) < 30, 8'($urandom), $urandom_range(99) < 30, 8'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(1) == 1) ? TS2 : TS1);
   endtask

   // Sends the first n symbols of cur_sym, with optional idle gaps and a clear
   // on symbol clr_at; err_first marks a COM that interrupts a set in progress.
   task automatic send_set(input int n, input int gap_pct, input int clr_at, input bit err_first);
      int bad;
      bit clr;
      bad = first_bad();
      for (int i = 0; i < n; i++) begin
         while (int'($urandom_range(99)) < gap_pct) begin
            applyStimulus(8'($urandom), 1'($urandom), 1'b0, 1'b0);
            m_vld = 1'b0;
            m_err = 1'b0;
            checkAll("idle");
         end
         clr = (i == clr_at);
         applyStimulus(cur_sym[i], cur_k[i], 1'b1, clr);
         m_vld = 1'b0;
         m_err = 1'b0;
         if ((i == 0 && err_first) || (i > 0 && i == bad)) begin
            m_err   = 1'b1;
            m_cnt   = 0;
            hist_ok = 1'b0;
         end else if (i == 15 && bad == 16) begin
            model_good_set(clr);
         end else if (clr) begin
            m_cnt   = 0;
            hist_ok = 1'b0;
         end
         checkAll($sformatf("sym%0d", i));
      end
      sym_vld   = 1'b0;
      clear_cnt = 1'b0;
   endtask

   initial begin
      int pick, clr_at, pos, seen0;
      rst = 1'b1;
      sym_in = '0; sym_k = 1'b0; sym_vld = 1'b0; clear_cnt = 1'b0;
      model_reset();
      #2;
      checkOutput("reset_async", all_outputs(), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_held", all_outputs(), 64'd0);
      rst = 1'b0;

      $display("[TB] eight back-to-back TS1 with PAD link/lane");
      build_set(1'b1, 8'h00, 1'b1, 8'h00, 8'h10, 8'h02, 8'h00, TS1);
      for (int s = 0; s < 8; s++) begin
         send_set(16, 0, -1, 1'b0);
         checkOutput("ts1_run_cnt", 64'(ts_cons_cnt), 64'(s + 1));
         checkOutput("ts1_run_hit", 64'(ts_cons_hit), 64'(s == 7));
         checkOutput("ts1_run_pads_type", 64'({link_pad, lane_pad, ts_type}), 64'(3'b110));
      end

      $display("[TB] four TS1 then TS2 with the same fields");
      for (int s = 0; s < 4; s++) send_set(16, 0, -1, 1'b0);
      for (int i = 6; i < 16; i++) cur_sym[i] = TS2;
      send_set(16, 0, -1, 1'b0);
      checkOutput("ts2_type", 64'(ts_type), 64'd1);
      checkOutput("ts2_cnt", 64'(ts_cons_cnt), 64'd1);

      $display("[TB] TS1 with a bad identifier at symbol 9");
      build_set(1'b1, 8'h00, 1'b1, 8'h00, 8'h10, 8'h02, 8'h00, TS1);
      cur_sym[9] = TS2;
      seen0 = vld_seen;
      send_set(16, 0, -1, 1'b0);
      checkOutput("bad_id_no_vld", 64'(vld_seen - seen0), 64'd0);
      checkOutput("bad_id_cnt", 64'(ts_cons_cnt), 64'd0);
      cur_sym[9] = TS1;
      send_set(16, 0, -1, 1'b0);
      checkOutput("after_bad_cnt", 64'(ts_cons_cnt), 64'd1);

      $display("[TB] COM arriving at symbol 7 restarts the set");
      send_set(7, 0, -1, 1'b0);
      send_set(16, 0, -1, 1'b1);
      checkOutput("restart_cnt", 64'(ts_cons_cnt), 64'd1);

      $display("[TB] TS1 with idle gaps");
      build_set(1'b0, 8'h01, 1'b0, 8'h03, 8'h10, 8'h02, 8'h00, TS1);
      seen0 = vld_seen;
      send_set(16, 30, -1, 1'b0);
      checkOutput("gap_vld_once", 64'(vld_seen - seen0), 64'd1);
      checkOutput("gap_fields", 64'({link_num, lane_num, n_fts, rate_id, train_ctl}),
                  64'(40'h01_03_10_02_00));

      $display("[TB] randomized sets with gaps, repeats, corruption and clears");
      for (int s = 0; s < 40; s++) begin
         pick   = int'($urandom_range(99));
         clr_at = ($urandom_range(99) < 10) ? int'($urandom_range(15)) : -1;
         if (pick < 35) begin
            build_random_set();
         end else if (pick < 55) begin
            build_random_set();
            pos = int'($urandom_range(15, 1));
            if ($urandom_range(1) == 1) begin
               cur_sym[pos] = 8'h1C;
               cur_k[pos]   = 1'b1;
            end else begin
               cur_sym[pos] = cur_sym[pos] ^ 8'h01;
            end
         end
         send_set(16, 30, clr_at, 1'b0);
      end

      $display("[TB] clear on the completing edge of the fifth identical TS1");
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
      m_vld = 1'b0; m_err = 1'b0; m_cnt = 0; hist_ok = 1'b0;
      checkAll("clear_only");
      build_set(1'b1, 8'h00, 1'b1, 8'h00, 8'h10, 8'h02, 8'h00, TS1);
      for (int s = 0; s < 4; s++) send_set(16, 0, -1, 1'b0);
      checkOutput("pre_clear_cnt", 64'(ts_cons_cnt), 64'd4);
      send_set(16, 0, 15, 1'b0);
      checkOutput("clear_coincide_cnt", 64'(ts_cons_cnt), 64'd1);
      checkOutput("clear_coincide_hit", 64'(ts_cons_hit), 64'd0);

      $display("[TB] reset in the middle of a set");
      send_set(8, 0, -1, 1'b0);
      rst = 1'b1;
      #2;
      checkOutput("midset_reset_async", all_outputs(), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("midset_reset_held", all_outputs(), 64'd0);
      rst = 1'b0;
      model_reset();
      send_set(16, 0, -1, 1'b0);
      checkOutput("post_reset_cnt", 64'(ts_cons_cnt), 64'd1);
      checkOutput("post_reset_vld_fields", 64'({link_pad, lane_pad, n_fts, rate_id}),
                  64'(18'b11_00010000_00000010));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/ts_rx_parser.md
TS_RX_PARSER -- requirements
Module: ts_rx_parser

Interface
REQ-001 The block SHALL have parameter CONS_TARGET, default 8, giving the number of consecutive identical ordered sets that raises ts_cons_hit; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1, sole clock, 1 GHz system clock.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port sym_in, input, 8, received symbol byte.
REQ-005 The block SHALL have port sym_k, input, 1, high when sym_in is a K-character.
REQ-006 The block SHALL have port sym_vld, input, 1, high when sym_in/sym_k are valid this cycle.
REQ-007 The block SHALL have port clear_cnt, input, 1, synchronous flush of the consecutive-match history.
REQ-008 The block SHALL have port ts_vld, output, 1, one-cycle pulse marking a good ordered set.
REQ-009 The block SHALL have port ts_type, output, 1, 0 = TS1 and 1 = TS2.
REQ-010 The block SHALL have ports link_num, lane_num, n_fts, rate_id and train_ctl, each output, 8 bits, holding symbols 1..5 of the last good ordered set.
REQ-011 The block SHALL have port link_pad, output, 1, high when symbol 1 was PAD.
REQ-012 The block SHALL have port lane_pad, output, 1, high when symbol 2 was PAD.
REQ-013 The block SHALL have port ts_cons_cnt, output, 4, consecutive identical count.
REQ-014 The block SHALL have port ts_cons_hit, output, 1, level, high when ts_cons_cnt >= CONS_TARGET.
REQ-015 The block SHALL have port ts_err, output, 1, one-cycle pulse on a malformed ordered set.

Function
REQ-016 Ordered-set layout SHALL be: sym0 COM (K, 8'hBC); sym1 link; sym2 lane; sym3 N_FTS; sym4 rate ID; sym5 training control; sym6..15 identifier, 8'h4A for TS1 or 8'h45 for TS2.
REQ-017 The FSM SHALL have two states: HUNT and COLLECT, with a 4-bit symbol index.
REQ-018 Only cycles with sym_vld=1 SHALL advance the FSM or index; sym_vld=0 cycles SHALL hold all state.
REQ-019 HUNT -> COLLECT with index=1 SHALL occur on a valid K 8'hBC; any other valid symbol in HUNT SHALL be dropped silently, with no ts_err.
REQ-020 sym1 and sym2 SHALL each be either K 8'hF7 (PAD, sets the pad flag) or any D-character; any other K SHALL be an error.
REQ-021 sym3..5 SHALL be D-characters, with any value accepted.
REQ-022 sym6 SHALL be D 8'h4A or 8'h45; sym7..15 SHALL be D and equal to sym6.
REQ-023 On a violation, ts_err SHALL pulse on the next cycle, ts_cons_cnt SHALL clear to 0, and the FSM SHALL return to HUNT.
REQ-024 If the violating symbol is K 8'hBC, the FSM SHALL instead go to COLLECT with index=1 (restart on new COM).
REQ-025 After sym15 is accepted with no violation, the FSM SHALL return to HUNT and, on the next cycle, SHALL pulse ts_vld for 1 cycle and update ts_type, the symbol fields and the pad flags simultaneously.
REQ-026 Latency SHALL be 1 clock from the sym15 sampling edge to ts_vld high.
REQ-027 Field outputs SHALL hold until the next good ordered set or reset.
REQ-028 A good set whose sym1..15 and K flags equal the stored previous good set SHALL increment ts_cons_cnt, saturating at 15.
REQ-029 A good set that differs from the previous good set, or arrives with no stored history, SHALL set ts_cons_cnt=1 and store the new set as history.
REQ-030 clear_cnt SHALL set ts_cons_cnt=0 and invalidate history on the next edge.
REQ-031 If clear_cnt coincides with the update edge of a good set, the set SHALL be stored and ts_cons_cnt SHALL become 1.
REQ-032 clear_cnt SHALL NOT affect the FSM or the index.
REQ-033 ts_cons_hit SHALL be registered from ts_cons_cnt in the same edge.
REQ-034 ts_err and ts_vld SHALL never be high in the same cycle.

Reset
REQ-035 While rst=1, the FSM SHALL be in HUNT with index=0 and history invalid.
REQ-036 While rst=1, all outputs SHALL be 0.
REQ-037 Reset asserted mid-COLLECT SHALL discard the partial set with no ts_err.
REQ-038 The first valid symbol after deassertion SHALL be treated as in HUNT.

Verification
REQ-039 The bench SHALL drive 8 back-to-back TS1 (link PAD, lane PAD, N_FTS 8'h10, rate 8'h02, ctl 0) -> ts_vld 8 pulses; ts_cons_cnt 1..8; ts_cons_hit rises with the 8th; link_pad=lane_pad=1; ts_type=0.
REQ-040 The bench SHALL drive 4 TS1 then TS2 with the same fields -> the TS2 gives ts_type=1 and ts_cons_cnt=1.
REQ-041 The bench SHALL drive a TS1 with sym9=8'h45 -> ts_err pulse, no ts_vld, ts_cons_cnt=0; the following good TS1 gives ts_cons_cnt=1.
REQ-042 The bench SHALL drive COM at sym7 followed by a complete TS1 -> one ts_err, then ts_vld for the restarted set.
REQ-043 The bench SHALL drive a TS1 with random sym_vld gaps (~30% idle) -> ts_vld exactly once, 1 cycle after the sym15 edge, with identical fields.
REQ-044 The bench SHALL assert clear_cnt on the sym15-update edge of the 5th identical TS1 -> ts_cons_cnt=1, ts_cons_hit=0, followed by rst mid-set -> all outputs 0 and no ts_err.
